// File: rtl/mem_arb_pkg.sv
// Types and constants shared by the memory-port arbiter, its interface and the sub-modules.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DBG_WAIT = 2'd1,
        S_DBG_RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DBG  = 2'd2
    } gnt_src_t;

    localparam logic [3:0] RAM_SEL_WORD = 4'hF;
    localparam int         STARVE_W     = 8;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the CPU MEM stage, the debug scanner, the shared RAM port and the arbiter.
interface mem_arb_if #(
    parameter int ADDR_BITS = 12
);
    import mem_arb_pkg::*;

    localparam int WA = ADDR_BITS - 2;

    logic                cpu_req;
    logic                cpu_rw;
    logic [WA-1:0]       cpu_addr;
    logic [3:0]          cpu_sel;
    logic                cpu_ext;
    logic [31:0]         cpu_wdata;
    logic [31:0]         cpu_rdata;
    logic                cpu_stall;

    logic                dbg_req;
    logic [WA-1:0]       dbg_addr;
    logic [31:0]         dbg_rdata;
    logic                dbg_valid;

    logic [WA-1:0]       ram_addr;
    logic [31:0]         ram_data_in;
    logic [3:0]          ram_sel;
    logic                ram_rw;
    logic                ram_extend_type;
    logic [31:0]         ram_data_out;

    arb_state_t          arb_state;
    logic [STARVE_W-1:0] starve_count;

    // Handshakes: cpu_req is sampled every cycle and cpu_stall=1 means the access was not
    // performed and must be presented again; dbg_req/dbg_addr are held stable until the
    // single-cycle dbg_valid strobe, which carries dbg_rdata.
    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_sel, cpu_ext, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_addr,
        output dbg_rdata, dbg_valid,
        output ram_addr, ram_data_in, ram_sel, ram_rw, ram_extend_type,
        input  ram_data_out,
        output arb_state, starve_count
    );

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_sel, cpu_ext, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_addr,
        input  dbg_rdata, dbg_valid,
        input  ram_addr, ram_data_in, ram_sel, ram_rw, ram_extend_type,
        output ram_data_out,
        input  arb_state, starve_count
    );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of cycles a debug request has waited without a grant.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    input  logic [STARVE_W-1:0] limit,
    output logic [STARVE_W-1:0] count,
    output logic                at_limit
);

    logic [STARVE_W-1:0] count_q;
    logic [STARVE_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q < limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == limit);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between the CPU MEM stage and a debug read scanner.
// Defining MEM_ARB_STATS_EN adds the 32-bit stall_cycles counter output.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int MAX_WAIT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    mem_arb_if.slave    bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int                  WA    = ADDR_BITS - 2;
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(MAX_WAIT);

    arb_state_t          state_q;
    arb_state_t          state_d;
    gnt_src_t            gnt;
    logic [31:0]         dbg_rdata_q;
    logic [31:0]         dbg_rdata_d;
    logic [STARVE_W-1:0] starve_count;
    logic                at_limit;
    logic                dbg_eligible;
    logic                starve_inc;
    logic                starve_clr;
    logic                cpu_stall_w;

    logic [WA-1:0]       ram_addr_w;
    logic [31:0]         ram_din_w;
    logic [3:0]          ram_sel_w;
    logic                ram_rw_w;
    logic                ram_ext_w;

    // The response cycle never takes a new debug read, capping the scanner at one read per 2 cycles.
    assign dbg_eligible = bus.dbg_req && (state_q != S_DBG_RESP);

    always_comb begin
        gnt = GNT_NONE;
        if (dbg_eligible && at_limit) begin
            gnt = GNT_DBG;
        end else if (bus.cpu_req) begin
            gnt = GNT_CPU;
        end else if (dbg_eligible) begin
            gnt = GNT_DBG;
        end
    end

    assign cpu_stall_w = dbg_eligible && at_limit && bus.cpu_req;

    always_comb begin
        ram_addr_w = '0;
        ram_din_w  = '0;
        ram_sel_w  = '0;
        ram_rw_w   = 1'b0;
        ram_ext_w  = 1'b0;
        case (gnt)
            GNT_CPU: begin
                ram_addr_w = bus.cpu_addr;
                ram_din_w  = bus.cpu_wdata;
                ram_sel_w  = bus.cpu_sel;
                ram_rw_w   = bus.cpu_rw;
                ram_ext_w  = bus.cpu_ext;
            end
            GNT_DBG: begin
                ram_addr_w = bus.dbg_addr;
                ram_sel_w  = RAM_SEL_WORD;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            S_IDLE, S_DBG_WAIT: begin
                if (gnt == GNT_DBG) begin
                    state_d     = S_DBG_RESP;
                    dbg_rdata_d = bus.ram_data_out;
                end else if (bus.dbg_req) begin
                    state_d = S_DBG_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign starve_inc = bus.dbg_req && (gnt != GNT_DBG);
    assign starve_clr = !bus.dbg_req || (gnt == GNT_DBG);

    mem_arb_starve_cnt u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .limit    (LIMIT),
        .count    (starve_count),
        .at_limit (at_limit)
    );

    assign bus.ram_addr        = ram_addr_w;
    assign bus.ram_data_in     = ram_din_w;
    assign bus.ram_sel         = ram_sel_w;
    assign bus.ram_rw          = ram_rw_w;
    assign bus.ram_extend_type = ram_ext_w;
    assign bus.cpu_rdata       = bus.ram_data_out;
    assign bus.cpu_stall       = cpu_stall_w;
    assign bus.dbg_rdata       = dbg_rdata_q;
    assign bus.dbg_valid       = (state_q == S_DBG_RESP);
    assign bus.arb_state       = state_q;
    assign bus.starve_count    = starve_count;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    assign stall_cycles_d = cpu_stall_w ? (stall_cycles_q + 32'd1) : stall_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_BITS, default 12, giving the byte-address width; word address = ADDR_BITS-2 bits.
REQ-002 The module SHALL have parameter MAX_WAIT, default 8, giving the debug starvation limit in cycles (legal range 1..255).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port cpu_req, input, 1 bit: the MEM stage requests the RAM port this cycle.
REQ-006 Ports cpu_rw (input, 1 bit; 1 = write), cpu_addr (input, ADDR_BITS-2), cpu_sel (input, 4), cpu_ext (input, 1) and cpu_wdata (input, 32): the CPU access.
REQ-007 Port cpu_rdata, output, 32 bits: equals ram_data_out combinationally.
REQ-008 Port cpu_stall, output, 1 bit: the CPU access was not performed this cycle; the pipeline holds MEM.
REQ-009 Port dbg_req, input, 1 bit: the debug scanner requests a read at dbg_addr (input, ADDR_BITS-2); dbg_req is held until dbg_valid.
REQ-010 Ports dbg_rdata (output, 32 bits) and dbg_valid (output, 1 bit): the registered debug read data and its one-cycle strobe.
REQ-011 Ports ram_addr, ram_data_in, ram_sel, ram_rw, ram_extend_type (outputs) and ram_data_out (input, 32 bits): the single shared RAM port, which has asynchronous read.

Function
REQ-012 The FSM SHALL have exactly three states: S_IDLE, S_DBG_WAIT (debug pending, not yet granted) and S_DBG_RESP (dbg_valid cycle).
REQ-013 Grant SHALL be combinational, evaluated in this priority order:
- (a) debug if dbg_req, state != S_DBG_RESP and starve_cnt == MAX_WAIT;
- (b) otherwise CPU if cpu_req;
- (c) otherwise debug if dbg_req and state != S_DBG_RESP;
- (d) otherwise none.
REQ-014 On a CPU grant, the ram_* outputs SHALL pass the cpu_* fields unchanged, and cpu_stall SHALL be 0.
REQ-015 On a debug grant:
- ram_rw = 0, ram_sel = 4'hF, ram_extend_type = 0, ram_addr = dbg_addr, ram_data_in = 0;
- ram_data_out is captured into dbg_rdata at the edge;
- next state is S_DBG_RESP.
REQ-016 cpu_stall SHALL be 1 only under grant case (a) with cpu_req = 1.
REQ-017 With no grant, the ram_* outputs SHALL be all-zero (read of address 0, no write).
REQ-018 dbg_valid SHALL be 1 exactly in S_DBG_RESP, i.e. the cycle after a debug grant, for one cycle.
- S_DBG_RESP always goes to S_IDLE.
- dbg_req is ignored in S_DBG_RESP; maximum debug rate is one read per 2 cycles.
REQ-019 starve_cnt (8 bits) SHALL:
- increment each cycle dbg_req = 1 without a debug grant;
- saturate at MAX_WAIT;
- clear on a debug grant or when dbg_req = 0.
REQ-020 Transitions for dbg_req = 1 without a grant: S_IDLE -> S_DBG_WAIT; S_DBG_WAIT stays in S_DBG_WAIT.
REQ-021 dbg_req dropping in S_DBG_WAIT SHALL return the FSM to S_IDLE with starve_cnt = 0 and no dbg_valid.
REQ-022 A CPU write and a debug read never share a cycle; the RAM SHALL never see two accesses in one cycle.
REQ-023 Worst-case debug latency SHALL be MAX_WAIT+1 cycles from dbg_req to grant.

Reset
REQ-024 Asserting rst at any time SHALL force: state S_IDLE, starve_cnt 0, dbg_valid 0, dbg_rdata 0.
REQ-025 A debug read in flight at reset SHALL be dropped; no dbg_valid follows.
REQ-026 The combinational outputs SHALL follow REQ-013..017 from the reset state.

Configuration
REQ-027 With macro MEM_ARB_STATS_EN defined, the module SHALL add output stall_cycles (32 bits).
- Reset value 0.
- Increments on every cycle with cpu_stall = 1; wraps at 2^32.
- Without the macro, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-028 Package mem_arb_pkg SHALL hold:
- the state enum (S_IDLE, S_DBG_WAIT, S_DBG_RESP);
- the grant-source encoding (GNT_NONE, GNT_CPU, GNT_DBG);
- the constant RAM_SEL_WORD = 4'hF.
REQ-029 The starvation counter SHALL be the sub-module mem_arb_starve_cnt: inputs inc, clr, limit; outputs count, at_limit.

Verification
REQ-030 cpu_req = 1, cpu_rw = 1, addr 5, wdata 32'hDEADBEEF, dbg_req = 0 -> same cycle: ram_rw = 1, ram_addr = 5, cpu_stall = 0.
REQ-031 dbg_req = 1, addr 9, cpu_req = 0, RAM[9] = 32'h12345678 -> grant on cycle 0; dbg_valid = 1 with dbg_rdata = 32'h12345678 on cycle 1; no grant on cycle 1 even with dbg_req held.
REQ-032 cpu_req and dbg_req held continuously, MAX_WAIT = 8:
- cycles 0..7: CPU grant, cpu_stall = 0;
- cycle 8: debug grant, cpu_stall = 1;
- cycle 9: dbg_valid = 1, CPU granted.
REQ-033 dbg_req pulsed for 3 cycles under continuous cpu_req -> starve_cnt returns to 0, FSM returns to S_IDLE, no dbg_valid.
REQ-034 rst asserted in the cycle of a debug grant -> dbg_valid stays 0, and starve_cnt = 0 after rst is released.
REQ-035 With MEM_ARB_STATS_EN, run the REQ-032 stimulus for 27 cycles -> stall_cycles = 3.
